iogroup1_mailbox: RTL and testbench
===================================

IOGROUP1_MAILBOX -- requirements
Module: iogroup1_mailbox

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk_i and rst_i.
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning the FIFO depth; legal values are powers of two from 2 to 256.
REQ-003 clk_i  in  1  sole clock; all state updates on the rising edge.
REQ-004 rst_i  in  1  asynchronous active-high reset.
REQ-005 areg1_i  in  32  control word: bit0 enable; bits[15:8] almost-full threshold THR; other bits ignored.
REQ-006 areg2_o  out  32  status word: bits[8:0] level; bit16 empty; bit17 full; bit18 ovf (sticky); bit19 udf (sticky); bit20 afull; other bits 0.
REQ-007 areg3_i  in  32  command word, sampled only when areg3_wr_i=1: bit18 clears ovf; bit19 clears udf; bit31 flushes the FIFO.
REQ-008 areg3_wr_i  in  1  single-cycle command strobe.
REQ-009 areg4o_i  in  32  push data, valid while areg4_wr_i=1.
REQ-010 areg4_wr_i  in  1  push request pulse.
REQ-011 areg4_rd_i  in  1  pop request pulse.
REQ-012 areg4i_o  out  32  pop data, valid in the cycle areg4_rack_o=1 and held until the next pop.
REQ-013 areg4_wack_o  out  1  push acknowledge, one cycle wide.
REQ-014 areg4_rack_o  out  1  pop acknowledge, one cycle wide.
REQ-015 irq_o  out  1  level interrupt, equal to afull OR ovf.

Function
REQ-016 Storage SHALL be a circular FIFO of DEPTH x 32 bits with log2(DEPTH)-bit read and write pointers that wrap modulo DEPTH, plus a level counter of 0..DEPTH.
REQ-017 Acknowledge latency SHALL be exactly 1 cycle: areg4_wack_o is the registered areg4_wr_i and areg4_rack_o is the registered areg4_rd_i, with no stall and no dependence on FIFO state.
REQ-018 Push with enable=1 and level<DEPTH SHALL write the data at wptr, increment wptr, and increment level.
REQ-019 Push with enable=1 and level=DEPTH SHALL discard the data, set ovf, and still be acknowledged.
REQ-020 Pop with enable=1 and level>0 SHALL register mem[rptr] into areg4i_o, increment rptr, and decrement level.
REQ-021 Pop with enable=1 and level=0 SHALL drive areg4i_o to 0x00000000, set udf, and still be acknowledged.
REQ-022 When enable=0, pushes SHALL be acknowledged and discarded, pops SHALL be acknowledged and return 0x00000000, and level, pointers and sticky flags SHALL be unchanged.
REQ-023 A simultaneous push and pop with level>0 SHALL perform both operations, leave level unchanged, and never set ovf, including at level=DEPTH.
REQ-024 A simultaneous push and pop with level=0 SHALL set udf, return 0x00000000, and store the pushed word, giving level 1.
REQ-025 Flush SHALL zero both pointers and level in the next cycle; a push or pop in the same cycle is acknowledged but has no effect on storage, level or flags.
REQ-026 Status flags SHALL be derived from level: empty = (level==0); full = (level==DEPTH); afull = (THR!=0 AND level>=THR).
REQ-027 A sticky-flag set event SHALL take priority over a clear command in the same cycle.
REQ-028 areg2_o and irq_o SHALL reflect registered state only, with no combinational path from any input.
REQ-029 RAM contents need not be reset; every readable path SHALL still return defined values.

Reset
REQ-030 While rst_i=1, asynchronously: pointers, level, ovf, udf, areg4i_o, areg4_wack_o, areg4_rack_o and irq_o SHALL be 0.
REQ-031 While rst_i=1, areg2_o SHALL be 0x00010000 (empty=1, all other bits 0).
REQ-032 Any push or pop pending when reset asserts SHALL be lost, with no acknowledge after reset release.
REQ-033 The first push or pop SHALL be accepted in the first rising edge after rst_i deasserts.

Verification
REQ-034 Scenario: enable=1; push 0x11111111, 0x22222222, then pop twice -> wack one cycle after each push; rack one cycle after each pop with areg4i_o 0x11111111 then 0x22222222; level 2 then 0, empty=1.
REQ-035 Scenario: DEPTH=8; push 9 words -> the 9th is acked and dropped; ovf=1, full=1, irq_o=1; the next 8 pops return the first 8 words in order.
REQ-036 Scenario: pop on an empty FIFO -> areg4i_o=0x00000000, rack=1, udf=1; then areg3 strobe with 0x00080000 -> udf=0.
REQ-037 Scenario: THR=3; push 3 words -> afull=1 and irq_o=1 after the 3rd push; one pop -> afull=0 and irq_o=0.
REQ-038 Scenario: full FIFO with simultaneous push and pop -> level stays 8, ovf stays 0, the oldest word is returned, and the new word is the last one popped.
REQ-039 Scenario: 5 words stored; flush strobe together with a push, then rst_i pulsed mid-sequence -> level 0 after the flush; all outputs 0 and areg2_o=0x00010000 during reset; no stray acknowledge after reset release.

Source files
------------

// File: rtl/iogroup1_mailbox_if.sv
// Mailbox register bus: control and status words, command strobe, and the
// push/pop data path with their one-cycle acknowledges.
//   slave  : the mailbox (drives status, pop data, acks, irq)
//   master : the host side (drives control, command, push/pop requests)
interface iogroup1_mailbox_if;
  logic [31:0] areg1_i;       // control: [0] enable, [15:8] almost-full threshold
  logic [31:0] areg2_o;       // status word
  logic [31:0] areg3_i;       // command: [18] clr ovf, [19] clr udf, [31] flush
  logic        areg3_wr_i;    // command strobe
  logic [31:0] areg4o_i;      // push data
  logic        areg4_wr_i;    // push request
  logic        areg4_rd_i;    // pop request
  logic [31:0] areg4i_o;      // pop data
  logic        areg4_wack_o;  // push ack
  logic        areg4_rack_o;  // pop ack
  logic        irq_o;         // afull | ovf

  modport slave (
    input  areg1_i, areg3_i, areg3_wr_i, areg4o_i, areg4_wr_i, areg4_rd_i,
    output areg2_o, areg4i_o, areg4_wack_o, areg4_rack_o, irq_o
  );

  modport master (
    output areg1_i, areg3_i, areg3_wr_i, areg4o_i, areg4_wr_i, areg4_rd_i,
    input  areg2_o, areg4i_o, areg4_wack_o, areg4_rack_o, irq_o
  );
endinterface

// File: rtl/iogroup1_mailbox.sv
// Register-mapped mailbox FIFO (DEPTH x 32).
//   clk_i  : sole clock, rising edge
//   rst_i  : asynchronous active-high reset
//   bus    : iogroup1_mailbox_if.slave -- control/status words, command
//            strobe, push/pop requests with 1-cycle acks, pop data, irq.
// Pushes and pops are always acknowledged one cycle later regardless of
// FIFO state; overflow/underflow are reported through sticky status bits.
module iogroup1_mailbox #(
  parameter int DEPTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  iogroup1_mailbox_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic          ovf_q, ovf_d, udf_q, udf_d;
  logic [31:0]   dout_q, dout_d;
  logic          wack_q, rack_q;
  logic [7:0]    thr_q;

  logic en, flush, is_empty, is_full;
  logic do_push, do_pop, set_ovf, set_udf;

  assign en       = bus.areg1_i[0];
  assign flush    = bus.areg3_wr_i & bus.areg3_i[31];
  assign is_empty = (lvl_q == '0);
  assign is_full  = (lvl_q == LW'(DEPTH));

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    lvl_d   = lvl_q;
    dout_d  = dout_q;
    do_push = 1'b0;
    do_pop  = 1'b0;
    set_ovf = 1'b0;
    set_udf = 1'b0;
    if (flush) begin
      // Flush wins over any same-cycle push/pop; those are acked only.
      wptr_d = '0;
      rptr_d = '0;
      lvl_d  = '0;
      if (bus.areg4_rd_i) dout_d = '0;
    end else if (en) begin
      if (bus.areg4_rd_i) begin
        if (!is_empty) begin
          do_pop = 1'b1;
          dout_d = mem[rptr_q];
        end else begin
          dout_d  = '0;
          set_udf = 1'b1;
        end
      end
      // A successful pop frees a slot this cycle, so push+pop on a full
      // FIFO is a pass-through rather than an overflow.
      if (bus.areg4_wr_i) begin
        if (!is_full || do_pop) do_push = 1'b1;
        else                    set_ovf = 1'b1;
      end
      if (do_push) wptr_d = wptr_q + PW'(1);
      if (do_pop)  rptr_d = rptr_q + PW'(1);
      lvl_d = lvl_q + LW'(do_push) - LW'(do_pop);
    end else if (bus.areg4_rd_i) begin
      dout_d = '0;
    end
    // Set beats clear when both happen in the same cycle.
    ovf_d = (ovf_q & ~(bus.areg3_wr_i & bus.areg3_i[18])) | set_ovf;
    udf_d = (udf_q & ~(bus.areg3_wr_i & bus.areg3_i[19])) | set_udf;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      lvl_q  <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
      dout_q <= '0;
      wack_q <= 1'b0;
      rack_q <= 1'b0;
      thr_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      lvl_q  <= lvl_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
      dout_q <= dout_d;
      wack_q <= bus.areg4_wr_i;
      rack_q <= bus.areg4_rd_i;
      thr_q  <= bus.areg1_i[15:8];
    end
  end

  // Storage is not reset; only slots below the level are ever read.
  always_ff @(posedge clk_i) begin
    if (do_push && !rst_i) mem[wptr_q] <= bus.areg4o_i;
  end

  // Status is built from registers only (threshold is registered too) so
  // there is no input-to-status combinational path.
  logic [8:0] lvl9;
  logic       afull;
  assign lvl9  = 9'(lvl_q);
  assign afull = (thr_q != 8'd0) && (lvl9 >= {1'b0, thr_q});

  assign bus.areg2_o      = {11'b0, afull, udf_q, ovf_q, is_full, is_empty, 7'b0, lvl9};
  assign bus.irq_o        = afull | ovf_q;
  assign bus.areg4i_o     = dout_q;
  assign bus.areg4_wack_o = wack_q;
  assign bus.areg4_rack_o = rack_q;

  logic unused_ok;
  assign unused_ok = ^{bus.areg1_i[31:16], bus.areg1_i[7:1],
                       bus.areg3_i[30:20], bus.areg3_i[17:0]};
endmodule

// File: tb/tb_iogroup1_mailbox.sv
module tb_iogroup1_mailbox;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  iogroup1_mailbox_if bus();
  iogroup1_mailbox #(.DEPTH(DEPTH)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int nchk = 0;
  int nerr = 0;

  // Reference model state
  logic [31:0] mq[$];
  logic [31:0] exp_q[$];
  bit          m_ovf = 0, m_udf = 0;
  logic [7:0]  m_thr = 0;
  logic [31:0] last_pop = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mstat();
    logic [31:0] s;
    int lvl;
    lvl = mq.size();
    s = '0;
    s[8:0] = 9'(lvl);
    s[16]  = (lvl == 0);
    s[17]  = (lvl == DEPTH);
    s[18]  = m_ovf;
    s[19]  = m_udf;
    s[20]  = (m_thr != 0) && (lvl >= int'(m_thr));
    return s;
  endfunction

  // One clock: drive, predict, clock, check acks/scoreboard/status.
  task automatic step(input bit wr, input logic [31:0] wd, input bit rd,
                      input bit cw, input logic [31:0] cmd);
    int lvl0;
    bit flush, pop_ok, push_ok, so, su;
    logic [31:0] st, e;
    bus.areg4_wr_i = wr; bus.areg4o_i = wd; bus.areg4_rd_i = rd;
    bus.areg3_wr_i = cw; bus.areg3_i = cmd;
    lvl0 = mq.size(); flush = cw && cmd[31]; so = 0; su = 0;
    if (flush) begin
      mq.delete();
      if (rd) exp_q.push_back(32'h0);
    end else if (bus.areg1_i[0]) begin
      pop_ok  = rd && lvl0 > 0;
      push_ok = wr && (lvl0 < DEPTH || pop_ok);
      if (rd) begin
        if (pop_ok) exp_q.push_back(mq.pop_front());
        else begin exp_q.push_back(32'h0); su = 1; end
      end
      if (wr) begin
        if (push_ok) mq.push_back(wd);
        else so = 1;
      end
    end else if (rd) begin
      exp_q.push_back(32'h0);
    end
    m_ovf = (m_ovf && !(cw && cmd[18])) || so;
    m_udf = (m_udf && !(cw && cmd[19])) || su;
    m_thr = bus.areg1_i[15:8];
    @(posedge clk); #1;
    bus.areg4_wr_i = 0; bus.areg4_rd_i = 0; bus.areg3_wr_i = 0; bus.areg3_i = 0;
    chk("wack", 32'(bus.areg4_wack_o), 32'(wr));
    chk("rack", 32'(bus.areg4_rack_o), 32'(rd));
    if (bus.areg4_rack_o) begin
      last_pop = bus.areg4i_o;
      if (exp_q.size() == 0) begin
        nchk++; nerr++;
        $display("FAIL rack_unexpected actual=1 expected=0");
      end else begin
        e = exp_q.pop_front();
        chk("pop_data", bus.areg4i_o, e);
      end
    end
    st = mstat();
    chk("status", bus.areg2_o, st);
    chk("irq", 32'(bus.irq_o), 32'(st[18] | st[20]));
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] wd;
    bit          rd;
    bit          cw;
    logic [31:0] cmd;
    logic [31:0] ctrl;
    int          lvl;
  } vec_t;

  vec_t tbl[11];

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_dout"}, bus.areg4i_o, 32'h0);
    chk({tag, "_wack"}, 32'(bus.areg4_wack_o), 32'h0);
    chk({tag, "_rack"}, 32'(bus.areg4_rack_o), 32'h0);
    chk({tag, "_irq"},  32'(bus.irq_o), 32'h0);
    chk({tag, "_stat"}, bus.areg2_o, 32'h0001_0000);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 32'h1111_1111, 1'b0, 1'b0, 32'h0,         32'h1, 1};
    tbl[1]  = '{1'b1, 32'h2222_2222, 1'b0, 1'b0, 32'h0,         32'h1, 2};
    tbl[2]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         32'h1, 1};
    tbl[3]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         32'h1, 0};
    tbl[4]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         32'h1, 0};
    tbl[5]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0008_0000, 32'h1, 0};
    tbl[6]  = '{1'b1, 32'hAAAA_AAAA, 1'b0, 1'b0, 32'h0,         32'h0, 0};
    tbl[7]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         32'h0, 0};
    tbl[8]  = '{1'b1, 32'hBBBB_BBBB, 1'b1, 1'b0, 32'h0,         32'h1, 1};
    tbl[9]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         32'h1, 0};
    tbl[10] = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0008_0000, 32'h1, 0};

    bus.areg1_i = 32'h1; bus.areg3_i = 0; bus.areg3_wr_i = 0;
    bus.areg4o_i = 0; bus.areg4_wr_i = 0; bus.areg4_rd_i = 0;

    // Reset state, then release between edges so the first push lands on
    // the very next rising edge.
    #12;
    chk_reset_outputs("reset");
    rst = 0;

    foreach (tbl[i]) begin
      bus.areg1_i = tbl[i].ctrl;
      step(tbl[i].wr, tbl[i].wd, tbl[i].rd, tbl[i].cw, tbl[i].cmd);
      chk($sformatf("tbl%0d_lvl", i), 32'(bus.areg2_o[8:0]), 32'(tbl[i].lvl));
    end
    bus.areg1_i = 32'h1;

    // Overflow: 9th push is acked and dropped.
    for (int i = 0; i < 9; i++) step(1, 32'hDEAD_0001 + 32'(i), 0, 0, 0);
    chk("ovf_set",  32'(bus.areg2_o[18]), 32'h1);
    chk("full_set", 32'(bus.areg2_o[17]), 32'h1);
    chk("ovf_irq",  32'(bus.irq_o), 32'h1);
    // Overflowing push with a clear in the same cycle: set wins.
    step(1, 32'h0BAD_0BAD, 0, 1, 32'h0004_0000);
    chk("ovf_set_beats_clr", 32'(bus.areg2_o[18]), 32'h1);
    step(0, 0, 0, 1, 32'h0004_0000);
    chk("ovf_cleared", 32'(bus.areg2_o[18]), 32'h0);
    // Full pass-through push+pop.
    step(1, 32'hCAFE_F00D, 1, 0, 0);
    chk("full_pp_lvl", 32'(bus.areg2_o[8:0]), 32'd8);
    chk("full_pp_ovf", 32'(bus.areg2_o[18]), 32'h0);
    chk("full_pp_old", bus.areg4i_o, 32'hDEAD_0001);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 0);
    chk("last_pop_new", last_pop, 32'hCAFE_F00D);

    // Almost-full threshold 3.
    bus.areg1_i = 32'h0000_0301;
    for (int i = 0; i < 3; i++) step(1, 32'h3000_0000 + 32'(i), 0, 0, 0);
    chk("afull_on",  32'(bus.areg2_o[20]), 32'h1);
    chk("afull_irq", 32'(bus.irq_o), 32'h1);
    step(0, 0, 1, 0, 0);
    chk("afull_off", 32'(bus.areg2_o[20]), 32'h0);
    chk("irq_off",   32'(bus.irq_o), 32'h0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    bus.areg1_i = 32'h1;

    // Flush with a same-cycle push, then reset with requests pending.
    for (int i = 0; i < 5; i++) step(1, 32'h5000_0000 + 32'(i), 0, 0, 0);
    step(1, 32'h5555_5555, 0, 1, 32'h8000_0000);
    chk("flush_lvl", 32'(bus.areg2_o[8:0]), 32'd0);
    step(1, 32'h6000_0001, 0, 0, 0);
    step(1, 32'h6000_0002, 1, 0, 0);
    bus.areg4_wr_i = 1; bus.areg4o_i = 32'h6000_0003; bus.areg4_rd_i = 1;
    #2 rst = 1;
    #1;
    chk_reset_outputs("midrst");
    mq.delete(); exp_q.delete(); m_ovf = 0; m_udf = 0; m_thr = 0;
    bus.areg4_wr_i = 0; bus.areg4_rd_i = 0;
    @(posedge clk); #1;
    chk_reset_outputs("midrst_hold");
    rst = 0;
    step(0, 0, 0, 0, 0);
    step(1, 32'h7777_7777, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("post_rst_pop", bus.areg4i_o, 32'h7777_7777);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
